song_recorder: RTL

- Capture side of the note-sequence interface. The auto-play path reads note sequences; this block writes them.
- Samples live keyboard keys and octave keys, and debounces them.
- Converts each held note, or each rest between notes, into a timed entry {octave, note, duration}.
- Stores entries in an internal buffer. The playback side reads the buffer through a synchronous read port, so a user-recorded song can be replayed.

---
 rtl/song_recorder_pkg.sv | 49 ++++
 rtl/song_recorder_key_debouncer.sv | 44 ++++
 rtl/song_recorder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/song_recorder_pkg.sv
// Shared note-sequence definitions used by both the recorder and the playback side:
// note and octave codes, recorder FSM states, entry field widths and key encoders.
package song_recorder_pkg;

  localparam int NOTE_W = 4;
  localparam int OCT_W  = 2;
  localparam int KEY_W  = 7;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_DO   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_RE   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_MI   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_FA   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_SOL  = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_LA   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_TI   = 4'd7;

  localparam logic [OCT_W-1:0] OCT_MID  = 2'd0;
  localparam logic [OCT_W-1:0] OCT_LOW  = 2'd1;
  localparam logic [OCT_W-1:0] OCT_HIGH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_NOTE,
    ST_FULL
  } rec_state_e;

  // Lowest-index pressed key wins; no key pressed is a rest.
  function automatic logic [NOTE_W-1:0] encode_note(input logic [KEY_W-1:0] keys);
    logic [NOTE_W-1:0] n;
    n = NOTE_REST;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (keys[i]) n = NOTE_W'(i + 1);
    end
    return n;
  endfunction

  function automatic logic [OCT_W-1:0] encode_octave(input logic [1:0] okeys);
    logic [OCT_W-1:0] o;
    case (okeys)
      2'b01:   o = OCT_LOW;
      2'b10:   o = OCT_HIGH;
      default: o = OCT_MID;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/song_recorder_key_debouncer.sv
// Tick-sampled two-stage stabiliser: a new input value is accepted once two
// consecutive tick samples agree. upd_o/chg_o pulse the cycle after each tick.
module key_debouncer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         tick_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o,
  output logic         upd_o,
  output logic         chg_o
);

  logic [W-1:0] samp_q;
  logic [W-1:0] stable_q;
  logic         upd_q;
  logic         chg_q;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      samp_q   <= '0;
      stable_q <= '0;
      upd_q    <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      upd_q <= tick_i;
      chg_q <= 1'b0;
      if (tick_i) begin
        samp_q <= raw_i;
        if (raw_i == samp_q) begin
          stable_q <= raw_i;
          chg_q    <= (raw_i != stable_q);
        end
      end
    end
  end

  assign stable_o = stable_q;
  assign upd_o    = upd_q;
  assign chg_o    = chg_q;

endmodule

// File: rtl/song_recorder.sv
// Records debounced keyboard input as timed {octave, note, duration} entries into
// an internal buffer that the playback side reads through a registered port.
module song_recorder
  import song_recorder_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int DUR_W       = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rec_enable,
  input  logic [KEY_W-1:0]                key_in,
  input  logic [1:0]                      octave_keys,
  input  logic [AW-1:0]                   rd_addr,
  output logic [OCT_W+NOTE_W+DUR_W-1:0]   rd_data,
  output logic [AW:0]                     rec_len,
  output logic                            recording,
  output logic                            full,
  output logic [NOTE_W-1:0]               cur_note
);

  localparam int                EW        = OCT_W + NOTE_W + DUR_W;
  localparam int                CW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]     TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [AW:0]       LEN_FULL  = (AW + 1)'(DEPTH);
  localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

  logic [CW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
  end

  logic [KEY_W+1:0] stable;
  logic             upd;
  logic             chg;

  key_debouncer #(.W(KEY_W + 2)) u_debounce (
    .clk      (clk),
    .rst_ni   (reset),
    .tick_i   (tick),
    .raw_i    ({octave_keys, key_in}),
    .stable_o (stable),
    .upd_o    (upd),
    .chg_o    (chg)
  );

  logic [NOTE_W-1:0] s_note;
  logic [OCT_W-1:0]  s_oct;

  assign s_note = encode_note(stable[KEY_W-1:0]);
  assign s_oct  = encode_octave(stable[KEY_W+1:KEY_W]);

  logic rec_en_q;
  logic rec_rise;
  logic rec_fall;

  assign rec_rise = rec_enable & ~rec_en_q;
  assign rec_fall = ~rec_enable & rec_en_q;

  rec_state_e        state_q, state_d;
  logic [AW:0]       len_q, len_d;
  logic              full_q, full_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [NOTE_W-1:0] cur_note_q;
  logic              wr_en;
  logic [EW-1:0]     wr_data;

  assign wr_data = {oct_q, note_q, dur_q};

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    full_d  = full_q;
    oct_d   = oct_q;
    note_d  = note_q;
    dur_d   = dur_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rec_rise) begin
          len_d   = '0;
          full_d  = 1'b0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (rec_fall) begin
          state_d = ST_IDLE;
        end else if (upd && s_note != NOTE_REST) begin
          note_d  = s_note;
          oct_d   = s_oct;
          dur_d   = DUR_ONE;
          state_d = ST_NOTE;
        end
      end
      ST_NOTE: begin
        if (rec_fall) begin
          wr_en   = (note_q != NOTE_REST);
          state_d = ST_IDLE;
        end else if (upd) begin
          if (s_note == note_q && dur_q != DUR_MAX) begin
            dur_d = dur_q + DUR_ONE;
          end else begin
            wr_en = 1'b1;
            dur_d = DUR_ONE;
            if (s_note != note_q) begin
              note_d = s_note;
              oct_d  = (s_note == NOTE_REST) ? OCT_MID : s_oct;
            end
          end
        end
      end
      ST_FULL: begin
        if (rec_fall) begin
          full_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Filling the last slot halts the session; a stop-time write just ends it.
    if (wr_en) begin
      len_d = len_q + (AW + 1)'(1);
      if (len_d == LEN_FULL && state_d != ST_IDLE) begin
        full_d  = 1'b1;
        state_d = ST_FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      full_q     <= 1'b0;
      oct_q      <= OCT_MID;
      note_q     <= NOTE_REST;
      dur_q      <= '0;
      rec_en_q   <= 1'b0;
      cur_note_q <= NOTE_REST;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      full_q   <= full_d;
      oct_q    <= oct_d;
      note_q   <= note_d;
      dur_q    <= dur_d;
      rec_en_q <= rec_enable;
      if (chg) cur_note_q <= s_note;
    end
  end

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_data_q;

  // NOTE: the buffer has no reset; entries at or beyond len_q are masked on read instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[len_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= ({1'b0, rd_addr} < len_q) ? mem[rd_addr] : '0;
  end

  assign rd_data   = rd_data_q;
  assign rec_len   = len_q;
  assign recording = (state_q == ST_ARMED) || (state_q == ST_NOTE);
  assign full      = full_q;
  assign cur_note  = cur_note_q;

endmodule
